// File: rtl/rpn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rpn_pkg                                               |
// | Desc     : Shared types and constants for the RPN sequencer:     |
// |            FSM state enum, operator codes, error codes.          |
// |            RPN_MUL_EN makes code 100 (MUL) a legal operator.     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package rpn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    POP_B = 3'd2,
    CAP_B = 3'd3,
    POP_A = 3'd4,
    CAP_A = 3'd5,
    EXEC  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

  // Operator codes the build understands; everything else is illegal.
  function automatic logic op_legal(input logic [2:0] op);
`ifdef RPN_MUL_EN
    return (op <= OP_MUL);
`else
    return (op <= OP_OR);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/rpn_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rpn_sequencer_if                                      |
// | Desc     : Token handshake bundle between a token producer       |
// |            (master) and the RPN sequencer (slave).               |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface rpn_sequencer_if #(
  parameter int WIDTH = 32
) ();

  logic             tok_valid;
  logic             tok_ready;
  logic             tok_is_op;
  logic [2:0]       tok_op;
  logic [WIDTH-1:0] tok_data;

  modport master (
    output tok_valid, tok_is_op, tok_op, tok_data,
    input  tok_ready
  );

  modport slave (
    input  tok_valid, tok_is_op, tok_op, tok_data,
    output tok_ready
  );

endinterface
`default_nettype wire

// File: rtl/rpn_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rpn_alu                                               |
// | Desc     : Combinational operator unit, result = a op b,         |
// |            truncated to WIDTH bits. MUL only with RPN_MUL_EN.    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic [2:0]       op,
  output logic      [WIDTH-1:0] result
);

  // Select the operation; illegal codes never reach EXEC, so default is don't-care zero.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
`ifdef RPN_MUL_EN
      OP_MUL:  result = a * b;
`endif
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rpn_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rpn_sequencer                                         |
// | Desc     : Reverse-Polish token sequencer driving an external    |
// |            stack: operands are pushed, operators pop b then a,   |
// |            compute a op b and push the result.                   |
// |            Optional: define RPN_MUL_EN to enable MUL (code 100). |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  rpn_sequencer_if.slave        tok,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic      [WIDTH-1:0] stk_data,
  input  wire logic [WIDTH-1:0] stk_dout,
  input  wire logic             stk_empty,
  input  wire logic             stk_full,
  output logic                  res_valid,
  output logic      [WIDTH-1:0] res_data,
  output logic                  err,
  output logic      [1:0]       err_code,
  input  wire logic             err_clr
);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_result;
  logic             tok_ready_q;

  assign tok.tok_ready = tok_ready_q;
  // The value pushed is always the result register (operand or computed).
  assign stk_data = result;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a),
    .b      (b),
    .op     (op_q),
    .result (alu_result)
  );

  // Sequencer FSM. Stack strobes are registered one state early: the stack
  // status seen on the way into POP/PUSH cannot change before that state,
  // so the strobe agrees with the empty/full decision taken in the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= OP_ADD;
      a           <= '0;
      b           <= '0;
      result      <= '0;
      tok_ready_q <= 1'b1;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tok.tok_valid && tok_ready_q) begin
            tok_ready_q <= 1'b0;
            if (!tok.tok_is_op) begin
              result   <= tok.tok_data;
              stk_push <= !stk_full;
              state    <= PUSH;
            end else if (op_legal(tok.tok_op)) begin
              op_q    <= tok.tok_op;
              stk_pop <= !stk_empty;
              state   <= POP_B;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_ILLEGAL;
              state    <= ERR;
            end
          end
        end
        PUSH: begin
          if (stk_full) begin
            err      <= 1'b1;
            err_code <= ERR_OVERFLOW;
            state    <= ERR;
          end else begin
            tok_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        POP_B: begin
          if (stk_empty) begin
            err      <= 1'b1;
            err_code <= ERR_UNDERFLOW;
            state    <= ERR;
          end else begin
            state <= CAP_B;
          end
        end
        CAP_B: begin
          b       <= stk_dout;
          stk_pop <= !stk_empty;
          state   <= POP_A;
        end
        POP_A: begin
          // b stays consumed on underflow here; the stack is not restored.
          if (stk_empty) begin
            err      <= 1'b1;
            err_code <= ERR_UNDERFLOW;
            state    <= ERR;
          end else begin
            state <= CAP_A;
          end
        end
        CAP_A: begin
          a     <= stk_dout;
          state <= EXEC;
        end
        EXEC: begin
          result    <= alu_result;
          res_data  <= alu_result;
          res_valid <= 1'b1;
          stk_push  <= !stk_full;
          state     <= PUSH;
        end
        ERR: begin
          if (err_clr) begin
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            tok_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
